// File: rtl/dvfs_transition_sequencer_if.sv
// Interface between the DVFS policy, the regulator/PLL control side and the
// transition sequencer. slave = sequencer view, master = environment view.
interface dvfs_transition_sequencer_if #(
    parameter int OPP_W  = 3,
    parameter int FREQ_W = 32,
    parameter int VOLT_W = 16
);
    logic [OPP_W-1:0]    target_opp;
    logic                target_valid;
    logic                target_ready;
    logic [8*FREQ_W-1:0] freq_table_flat;
    logic [8*VOLT_W-1:0] volt_table_flat;
    logic [15:0]         settle_cycles;
    logic                volt_req;
    logic [VOLT_W-1:0]   volt_target;
    logic                volt_ack;
    logic                pll_req;
    logic [FREQ_W-1:0]   pll_freq;
    logic                pll_lock;
    logic [OPP_W-1:0]    cur_opp;
    logic                busy;
    logic                done;
    logic                error;
    logic [1:0]          err_code;
    logic                err_clr;

    modport slave (
        input  target_opp, target_valid, freq_table_flat, volt_table_flat,
               settle_cycles, volt_ack, pll_lock, err_clr,
        output target_ready, volt_req, volt_target, pll_req, pll_freq,
               cur_opp, busy, done, error, err_code
    );

    modport master (
        output target_opp, target_valid, freq_table_flat, volt_table_flat,
               settle_cycles, volt_ack, pll_lock, err_clr,
        input  target_ready, volt_req, volt_target, pll_req, pll_freq,
               cur_opp, busy, done, error, err_code
    );
endinterface

// File: rtl/dvfs_transition_sequencer.sv
// Sequences regulator and PLL for an OPP change: voltage-first going up,
// frequency-first going down. All outputs are registered.
module dvfs_transition_sequencer #(
    parameter int OPP_W       = 3,
    parameter int FREQ_W      = 32,
    parameter int VOLT_W      = 16,
    parameter int TIMEOUT_CYC = 4096,
    parameter int LOCK_BLANK  = 4
) (
    input  logic clk,
    input  logic rst_n,
    dvfs_transition_sequencer_if.slave bus
);
    localparam int TO_BITS = $clog2(TIMEOUT_CYC) + 1;
    localparam int CNT_W   = (TO_BITS > 16) ? TO_BITS : 16;
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] BLANK_END    = CNT_W'(LOCK_BLANK);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_V_REQ    = 3'd1,
        S_V_SETTLE = 3'd2,
        S_F_REQ    = 3'd3,
        S_PLL_WAIT = 3'd4,
        S_COMMIT   = 3'd5,
        S_ERROR    = 3'd6
    } state_t;

    state_t              state_r, state_nxt_s;
    logic [CNT_W-1:0]    cnt_r, cnt_nxt_s;
    logic [OPP_W-1:0]    tgt_r;
    logic                up_r;
    logic [FREQ_W-1:0]   freq_hold_r, freq_sel_s;
    logic [VOLT_W-1:0]   volt_hold_r, volt_sel_s;
    logic                accept_s;

    logic                target_ready_r, volt_req_r, pll_req_r, busy_r, done_r, error_r;
    logic [VOLT_W-1:0]   volt_target_r, volt_target_nxt_s;
    logic [FREQ_W-1:0]   pll_freq_r, pll_freq_nxt_s;
    logic [OPP_W-1:0]    cur_opp_r, cur_opp_nxt_s;
    logic [1:0]          err_code_r, err_code_nxt_s;

    assign freq_sel_s = bus.freq_table_flat[int'(bus.target_opp) * FREQ_W +: FREQ_W];
    assign volt_sel_s = bus.volt_table_flat[int'(bus.target_opp) * VOLT_W +: VOLT_W];
    assign accept_s   = (state_r == S_IDLE) && (state_nxt_s != S_IDLE);

    // State and phase counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
            cnt_r   <= '0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Next-state and counter logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (bus.target_valid && (bus.target_opp > cur_opp_r)) state_nxt_s = S_V_REQ;
                else if (bus.target_valid && (bus.target_opp < cur_opp_r)) state_nxt_s = S_F_REQ;
                else state_nxt_s = S_IDLE;
            end
            S_V_REQ: begin
                if (bus.volt_ack) state_nxt_s = S_V_SETTLE;
                else if (cnt_r == TIMEOUT_LAST) state_nxt_s = S_ERROR;
                else state_nxt_s = S_V_REQ;
            end
            S_V_SETTLE: begin
                if (cnt_r == '0) state_nxt_s = up_r ? S_F_REQ : S_COMMIT;
                else state_nxt_s = S_V_SETTLE;
            end
            S_F_REQ:  state_nxt_s = S_PLL_WAIT;
            S_PLL_WAIT: begin
                // lock is only trusted once the blanking window has elapsed
                if (bus.pll_lock && (cnt_r >= BLANK_END)) state_nxt_s = up_r ? S_COMMIT : S_V_REQ;
                else if (cnt_r == TIMEOUT_LAST) state_nxt_s = S_ERROR;
                else state_nxt_s = S_PLL_WAIT;
            end
            S_COMMIT: state_nxt_s = S_IDLE;
            S_ERROR: begin
                if (bus.err_clr) state_nxt_s = S_IDLE;
                else state_nxt_s = S_ERROR;
            end
            default:  state_nxt_s = S_IDLE;
        endcase

        cnt_nxt_s = cnt_r;
        if (state_nxt_s != state_r) begin
            if (state_nxt_s == S_V_SETTLE) cnt_nxt_s = CNT_W'(bus.settle_cycles);
            else cnt_nxt_s = '0;
        end else if (state_r == S_V_SETTLE) begin
            cnt_nxt_s = cnt_r - CNT_ONE;
        end else if ((state_r == S_V_REQ) || (state_r == S_PLL_WAIT)) begin
            cnt_nxt_s = cnt_r + CNT_ONE;
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Next values of the registered outputs, derived from the upcoming state
    always_comb begin
        volt_target_nxt_s = volt_target_r;
        pll_freq_nxt_s    = pll_freq_r;
        cur_opp_nxt_s     = cur_opp_r;
        err_code_nxt_s    = err_code_r;

        // the IDLE exit uses the live table; later phases use the snapshot
        if ((state_nxt_s == S_V_REQ) && (state_r != S_V_REQ)) begin
            volt_target_nxt_s = (state_r == S_IDLE) ? volt_sel_s : volt_hold_r;
        end else begin
            volt_target_nxt_s = volt_target_r;
        end

        if ((state_nxt_s == S_F_REQ) && (state_r != S_F_REQ)) begin
            pll_freq_nxt_s = (state_r == S_IDLE) ? freq_sel_s : freq_hold_r;
        end else begin
            pll_freq_nxt_s = pll_freq_r;
        end

        if (state_nxt_s == S_COMMIT) cur_opp_nxt_s = tgt_r;
        else cur_opp_nxt_s = cur_opp_r;

        if ((state_nxt_s == S_ERROR) && (state_r == S_V_REQ)) err_code_nxt_s = 2'b01;
        else if ((state_nxt_s == S_ERROR) && (state_r == S_PLL_WAIT)) err_code_nxt_s = 2'b10;
        else if (state_nxt_s == S_IDLE) err_code_nxt_s = 2'b00;
        else err_code_nxt_s = err_code_r;
    end

    // Request snapshot taken at accept so table updates cannot disturb a transition
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tgt_r       <= '0;
            up_r        <= 1'b0;
            freq_hold_r <= '0;
            volt_hold_r <= '0;
        end else if (accept_s) begin
            tgt_r       <= bus.target_opp;
            up_r        <= (bus.target_opp > cur_opp_r);
            freq_hold_r <= freq_sel_s;
            volt_hold_r <= volt_sel_s;
        end else begin
            tgt_r       <= tgt_r;
            up_r        <= up_r;
            freq_hold_r <= freq_hold_r;
            volt_hold_r <= volt_hold_r;
        end
    end

    // Output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            target_ready_r <= 1'b1;
            volt_req_r     <= 1'b0;
            pll_req_r      <= 1'b0;
            busy_r         <= 1'b0;
            done_r         <= 1'b0;
            error_r        <= 1'b0;
            volt_target_r  <= '0;
            pll_freq_r     <= '0;
            cur_opp_r      <= '0;
            err_code_r     <= 2'b00;
        end else begin
            target_ready_r <= (state_nxt_s == S_IDLE);
            volt_req_r     <= (state_nxt_s == S_V_REQ);
            pll_req_r      <= (state_nxt_s == S_F_REQ);
            busy_r         <= (state_nxt_s != S_IDLE);
            done_r         <= (state_nxt_s == S_COMMIT);
            error_r        <= (state_nxt_s == S_ERROR);
            volt_target_r  <= volt_target_nxt_s;
            pll_freq_r     <= pll_freq_nxt_s;
            cur_opp_r      <= cur_opp_nxt_s;
            err_code_r     <= err_code_nxt_s;
        end
    end

    assign bus.target_ready = target_ready_r;
    assign bus.volt_req     = volt_req_r;
    assign bus.volt_target  = volt_target_r;
    assign bus.pll_req      = pll_req_r;
    assign bus.pll_freq     = pll_freq_r;
    assign bus.cur_opp      = cur_opp_r;
    assign bus.busy         = busy_r;
    assign bus.done         = done_r;
    assign bus.error        = error_r;
    assign bus.err_code     = err_code_r;
endmodule

// File: doc/dvfs_transition_sequencer.md
Name: dvfs_transition_sequencer

Overview:
- Executes operating-point changes requested by the DVFS policy block by sequencing the voltage regulator and the core PLL in a safe order.
- Up-transitions (higher OPP) raise voltage first, wait for regulator settle, then retune the PLL.
- Down-transitions retune the PLL first, then lower voltage.
- Sits between the DVFS policy output (opp index plus 8-entry freq/volt tables) and the PMIC/PLL control interfaces. Reports the committed OPP and error status.

Parameters:
- OPP_W, 3, OPP index width (8 entries)
- FREQ_W, 32, frequency code width
- VOLT_W, 16, voltage code width
- TIMEOUT_CYC, 4096, max cycles waiting on volt_ack or pll_lock
- LOCK_BLANK, 4, cycles after pll_req during which pll_lock is ignored

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- target_opp  in  OPP_W  requested OPP index
- target_valid  in  1  request valid
- target_ready  out  1  high only in IDLE; request accepted on valid&&ready
- freq_table_flat  in  8*FREQ_W  entry i at bits [i*FREQ_W +: FREQ_W]
- volt_table_flat  in  8*VOLT_W  entry i at bits [i*VOLT_W +: VOLT_W]
- settle_cycles  in  16  regulator settle wait after volt_ack
- volt_req  out  1  voltage change request, level
- volt_target  out  VOLT_W  requested voltage code
- volt_ack  in  1  regulator reached target
- pll_req  out  1  one-cycle PLL retune pulse
- pll_freq  out  FREQ_W  requested frequency code
- pll_lock  in  1  PLL locked, level
- cur_opp  out  OPP_W  last fully committed OPP
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse on commit
- error  out  1  sticky, set in ERROR state
- err_code  out  2  01 = volt timeout, 10 = PLL timeout, 00 = none
- err_clr  in  1  leave ERROR

Behaviour:
- Reset values:
  - cur_opp = 0, volt_req = 0, volt_target = 0, pll_req = 0, pll_freq = 0.
  - busy = 0, done = 0, error = 0, err_code = 00, state = IDLE.
  - Reset mid-transition aborts immediately to these values; no completion pulse.
- States: IDLE, V_REQ, V_SETTLE, F_REQ, PLL_WAIT, COMMIT, ERROR.
- Direction flag `up` is latched at accept.
- IDLE:
  - On accept, latch tgt = target_opp.
  - tgt == cur_opp: no-op. Stay IDLE, no done, no handshakes.
  - tgt > cur_opp: up = 1, go to V_REQ.
  - tgt < cur_opp: up = 0, go to F_REQ.
  - Table entries are sampled when entering V_REQ or F_REQ and held; later table changes do not affect the transition in flight.
- V_REQ:
  - volt_req = 1 and volt_target = volt_table[tgt], held stable until volt_ack is sampled high.
  - On ack: volt_req drops on the next edge, counter <= settle_cycles, go to V_SETTLE.
  - Timeout counter reaches TIMEOUT_CYC: go to ERROR with err_code = 01, volt_req = 0.
- V_SETTLE:
  - If counter == 0, advance; else decrement. Occupancy is settle_cycles+1 cycles.
  - Next state: F_REQ if up, else COMMIT.
- F_REQ:
  - pll_freq = freq_table[tgt] (held until the next F_REQ).
  - pll_req = 1 for exactly one cycle, then go to PLL_WAIT.
- PLL_WAIT:
  - pll_lock is ignored for the first LOCK_BLANK cycles, then sampled.
  - On lock: COMMIT if up, else V_REQ.
  - Timeout (TIMEOUT_CYC cycles including blank): go to ERROR with err_code = 10.
- COMMIT: cur_opp <= tgt, done = 1 for one cycle, return to IDLE. Back-to-back accept is possible on the next cycle.
- ERROR:
  - target_ready = 0, cur_opp unchanged, error = 1.
  - On err_clr: error = 0, err_code = 00, return to IDLE.
- Arbitration and ordering:
  - Requests during busy are not accepted (target_ready = 0); the requester holds them.
  - volt_ack arriving outside V_REQ and pll_lock outside PLL_WAIT are ignored.
- Timeout counter: 13 bits minimum, cleared on every state entry.

Test Plan:
- Up path: cur_opp = 2, request 5, settle_cycles = 10, volt_ack after 3 cycles, pll_lock after 6 → ordering is volt_req then pll_req; volt_target = volt_table[5], pll_freq = freq_table[5]; done once; cur_opp = 5; no pll_req before settle expires.
- Down path: cur_opp = 5, request 1 → pll_req (freq_table[1]) precedes volt_req (volt_table[1]); settle_cycles = 0 gives 1-cycle V_SETTLE; cur_opp = 1.
- No-op: cur_opp = 3, request 3 → target_ready stays 1, busy stays 0, no done/volt_req/pll_req.
- PLL timeout: pll_lock held 0 → ERROR after 4096 cycles; error = 1, err_code = 10, cur_opp unchanged. A request while in ERROR is not accepted; err_clr returns to IDLE with error = 0.
- Blanking/stale signals: pll_lock held 1 through pll_req → not honoured before LOCK_BLANK = 4 cycles elapse. A volt_ack pulse in IDLE is ignored.
- Reset mid-V_SETTLE: rst_n asserted → all outputs return to reset values at once; after release, cur_opp = 0 and target_ready = 1.
